seq_bit_sampler: RTL
====================

Name: seq_bit_sampler

Overview:
- Input-conditioning stage directly upstream of the sequence detector.
- Takes a raw data switch and a raw "step" push-button and synchronises and debounces both.
- Emits exactly one qualified serial bit per button press, as a one-cycle strobe plus a held level; the detector consumes this as its x input.
- Also keeps a short history register and a press counter for the display/debug path.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a debounced level changes. Must be >= 2.
- HIST_W, 8: width of the entered-bit history shift register.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- data_raw  in  1  asynchronous data switch (bit value to enter)
- step_raw  in  1  asynchronous push-button; each press enters one bit
- data_db  out  1  debounced data level
- step_db  out  1  debounced button level
- bit_out  out  1  last entered bit, held until the next entry
- bit_valid  out  1  one-cycle strobe, high in the cycle bit_out updates
- history  out  HIST_W  entered bits; newest at LSB
- bit_count  out  8  number of bits entered, saturating at 255

Behaviour:
- Reset (rst high at a clk edge) clears all state:
  - sync flops, debounce counters, data_db, step_db and step edge register all go to 0.
  - bit_out, bit_valid, history and bit_count all go to 0.
  - Reset has priority over every other event.
- Synchroniser: each raw input passes through 2 flops (s1, s2). There is no logic between them.
- Debounce filter, one per input:
  - An up-counter of width clog2(DEBOUNCE_CYCLES) increments on every edge where s2 != db.
  - It clears to 0 on any edge where s2 == db.
  - On the edge where s2 != db and the counter == DEBOUNCE_CYCLES-1, db takes s2 and the counter clears.
  - Latency: a raw level that is stable and meets setup before edge 0 appears on db after edge 1+DEBOUNCE_CYCLES.
  - A pulse shorter than DEBOUNCE_CYCLES cycles at s2 produces no db change.
- Step edge detect:
  - step_db_q is step_db registered.
  - A press is detected when step_db==1 and step_db_q==0.
  - Button release produces nothing.
- On the edge following press detection:
  - bit_valid=1 and bit_out=data_db, taking the value of data_db in the detect cycle, i.e. its pre-edge value.
  - history = {history[HIST_W-2:0], data_db}.
  - bit_count increments, saturating at 255. history keeps shifting after saturation.
- In all other cycles bit_valid=0, and bit_out, history and bit_count hold.
- Simultaneous events: if data_db flips on the same edge that step_db rises, the entered bit is data_db's new value. Detection happens one cycle later, when data_db already holds that value.
- Button held through reset: after reset step_db=0. The held button therefore debounces to 1 and produces exactly one press after 1+DEBOUNCE_CYCLES cycles.
- Minimum press spacing: 2*DEBOUNCE_CYCLES cycles, i.e. a full debounce high plus a full debounce low. Bits are never dropped or duplicated for longer presses.

Decomposition:
- Shared package holds:
  - SYNC_STAGES = 2
  - DEFAULT_DEBOUNCE = 16
  - BIT_COUNT_W = 8 and BIT_COUNT_MAX = 255
- One sub-module, debounce_filter (clk, rst, raw_in, db_out; parameter DEBOUNCE_CYCLES). It contains the synchroniser plus counter and is instantiated twice.
- Edge detect, history and counter logic stay in seq_bit_sampler.

Test Plan (DEBOUNCE_CYCLES=4, HIST_W=8):
1. Reset check: rst high 2 cycles with raw inputs toggling -> all outputs 0 throughout and on the cycle after rst falls.
2. Debounce latency: data_raw 0->1 before edge 0, held -> data_db still 0 after edge 4, and 1 after edge 5. No bit_valid.
3. Glitch rejection: step_raw high for 3 cycles, then low -> step_db stays 0, bit_valid never asserts, bit_count=0.
4. Sequence entry: enter 1,0,0,1 with 10-cycle presses and 10-cycle gaps -> four single-cycle bit_valid pulses with bit_out 1,0,0,1; afterwards history=8'h09 and bit_count=4.
5. Saturation: 260 presses with data=1 -> bit_count=255 after press 255 and stays 255; history=8'hFF; bit_valid still pulses on every press.
6. Mid-operation reset: step_raw held, rst pulsed for 1 cycle when the counter is at 2 -> no pulse. After rst falls, exactly one bit_valid at edge 1+4+1 = 6 after reset release. bit_count=1.

Source files
------------

// File: rtl/seq_bit_sampler_pkg.sv
// Shared constants and helpers for the serial-bit input conditioning stage.
//   SYNC_STAGES      : flops in each input synchroniser
//   DEFAULT_DEBOUNCE : default stable-cycle count for the debounce filters
//   BIT_COUNT_W/MAX  : width and saturation value of the press counter
package seq_bit_sampler_pkg;

    localparam int unsigned SYNC_STAGES      = 2;
    localparam int unsigned DEFAULT_DEBOUNCE = 16;
    localparam int unsigned BIT_COUNT_W      = 8;

    localparam logic [BIT_COUNT_W-1:0] BIT_COUNT_MAX = 8'd255;
    localparam logic [BIT_COUNT_W-1:0] BIT_COUNT_ONE = 8'd1;

    // Increment that sticks at BIT_COUNT_MAX instead of wrapping.
    function automatic logic [BIT_COUNT_W-1:0] sat_inc(input logic [BIT_COUNT_W-1:0] v);
        return (v == BIT_COUNT_MAX) ? v : v + BIT_COUNT_ONE;
    endfunction

endpackage

// File: rtl/seq_bit_sampler_debounce_filter.sv
// Two-flop synchroniser followed by a stable-count debounce filter.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset
//   raw_in : asynchronous raw level
//   db_out : debounced level; follows the synchronised input only after it has
//            differed from db_out for DEBOUNCE_CYCLES consecutive edges
module debounce_filter
    import seq_bit_sampler_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic db_out
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Counter only runs while the synchronised input disagrees with the
    // debounced level; any agreement restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_out != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_out;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign db_out = db_q;

endmodule

// File: rtl/seq_bit_sampler.sv
// Conditions a raw data switch and step button into one qualified serial bit
// per button press for the downstream sequence detector.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   data_raw  : asynchronous data switch, value of the bit to enter
//   step_raw  : asynchronous push-button, one bit entered per press
//   data_db   : debounced data level
//   step_db   : debounced button level
//   bit_out   : last entered bit, held until the next entry
//   bit_valid : one-cycle strobe in the cycle bit_out updates
//   history   : entered bits, newest at LSB
//   bit_count : number of bits entered, saturating at 255
module seq_bit_sampler
    import seq_bit_sampler_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int unsigned HIST_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data_raw,
    input  logic                   step_raw,
    output logic                   data_db,
    output logic                   step_db,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic [HIST_W-1:0]      history,
    output logic [BIT_COUNT_W-1:0] bit_count
);

    logic                   step_db_q;
    logic                   press;
    logic                   bit_out_q, bit_out_d;
    logic                   bit_valid_q, bit_valid_d;
    logic [HIST_W-1:0]      history_q, history_d;
    logic [BIT_COUNT_W-1:0] bit_count_q, bit_count_d;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_data_db (
        .clk    (clk),
        .rst    (rst),
        .raw_in (data_raw),
        .db_out (data_db)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .rst    (rst),
        .raw_in (step_raw),
        .db_out (step_db)
    );

    // Rising edge of the debounced button; release is ignored.
    assign press = step_db & ~step_db_q;

    // data_db is sampled in the detect cycle, so a data change landing on the
    // same edge as the step rise is already visible here.
    always_comb begin
        bit_valid_d = press;
        bit_out_d   = bit_out_q;
        history_d   = history_q;
        bit_count_d = bit_count_q;
        if (press) begin
            bit_out_d   = data_db;
            history_d   = {history_q[HIST_W-2:0], data_db};
            bit_count_d = sat_inc(bit_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_db_q   <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            history_q   <= '0;
            bit_count_q <= '0;
        end else begin
            step_db_q   <= step_db;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            history_q   <= history_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign history   = history_q;
    assign bit_count = bit_count_q;

endmodule
